// File: rtl/tennis_referee.sv
// rtl/tennis_referee.sv - tennis game referee: hit windows, miss timing, score and serve flow
module tennis_referee #(
  parameter int HIT_WINDOW  = 3,
  parameter int MISS_CYCLES = 4,
  parameter int POINT_PAUSE = 8,
  parameter int WIN_SCORE   = 7
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] ball_i,
  input  logic        left_btn_i,
  input  logic        right_btn_i,
  output logic        left_trigger_o,
  output logic        right_trigger_o,
  output logic [3:0]  score_left_o,
  output logic [3:0]  score_right_o,
  output logic        point_left_o,
  output logic        point_right_o,
  output logic        rally_active_o,
  output logic        game_over_o,
  output logic        winner_left_o
);

  localparam int MW = $clog2(MISS_CYCLES + 1);
  localparam int PW = $clog2(POINT_PAUSE + 1);
  localparam logic [15:0] RIGHT_MASK = 16'((32'd1 << HIT_WINDOW) - 32'd1);
  localparam logic [15:0] LEFT_MASK  = 16'(RIGHT_MASK << (16 - HIT_WINDOW));

  typedef enum logic [1:0] {SERVE, RALLY, POINT, GAME_OVER} state_t;

  state_t          state_q;
  logic            server_left_q;
  logic            dir_left_q;      // 1: ball travelling towards the left player
  logic            lock_left_q;
  logic            lock_right_q;
  logic [MW-1:0]   miss_q;
  logic [PW-1:0]   pause_q;
  logic [3:0]      score_left_q;
  logic [3:0]      score_right_q;
  logic            left_trig_q;
  logic            right_trig_q;
  logic            point_left_q;
  logic            point_right_q;
  logic            game_over_q;
  logic            winner_left_q;

  // Receiver-side view of the ball and buttons; a malformed ball is never in a window or at an end
  logic ball_valid;
  logic recv_press;
  logic recv_in_win;
  logic recv_at_end;
  logic recv_locked;
  logic recv_hit;
  logic miss_expire;
  logic [3:0] server_score;

  assign ball_valid   = (ball_i != 16'd0) && ((ball_i & (ball_i - 16'd1)) == 16'd0);
  assign recv_press   = dir_left_q ? left_btn_i : right_btn_i;
  assign recv_in_win  = ball_valid && ((ball_i & (dir_left_q ? LEFT_MASK : RIGHT_MASK)) != 16'd0);
  assign recv_at_end  = ball_valid && (dir_left_q ? ball_i[15] : ball_i[0]);
  assign recv_locked  = dir_left_q ? lock_left_q : lock_right_q;
  assign recv_hit     = recv_press && recv_in_win && !recv_locked;
  assign miss_expire  = recv_at_end && (miss_q == MW'(MISS_CYCLES - 1));
  assign server_score = server_left_q ? score_left_q : score_right_q;

  // Game state machine with all outputs held in registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= SERVE;
      server_left_q <= 1'b0;
      dir_left_q    <= 1'b1;
      lock_left_q   <= 1'b0;
      lock_right_q  <= 1'b0;
      miss_q        <= '0;
      pause_q       <= '0;
      score_left_q  <= 4'd0;
      score_right_q <= 4'd0;
      left_trig_q   <= 1'b0;
      right_trig_q  <= 1'b0;
      point_left_q  <= 1'b0;
      point_right_q <= 1'b0;
      game_over_q   <= 1'b0;
      winner_left_q <= 1'b0;
    end else begin
      left_trig_q   <= 1'b0;
      right_trig_q  <= 1'b0;
      point_left_q  <= 1'b0;
      point_right_q <= 1'b0;
      case (state_q)
        SERVE: begin
          if (server_left_q ? left_btn_i : right_btn_i) begin
            left_trig_q  <= server_left_q;
            right_trig_q <= !server_left_q;
            dir_left_q   <= !server_left_q;
            lock_left_q  <= 1'b0;
            lock_right_q <= 1'b0;
            miss_q       <= '0;
            state_q      <= RALLY;
          end
        end
        RALLY: begin
          if (recv_hit) begin
            // A valid return beats a simultaneous miss expiry
            left_trig_q  <= dir_left_q;
            right_trig_q <= !dir_left_q;
            dir_left_q   <= !dir_left_q;
            lock_left_q  <= 1'b0;
            lock_right_q <= 1'b0;
            miss_q       <= '0;
          end else begin
            if (recv_press && !recv_in_win) begin
              if (dir_left_q) lock_left_q <= 1'b1;
              else            lock_right_q <= 1'b1;
            end
            if (!recv_at_end) begin
              miss_q <= '0;
            end else if (!miss_expire) begin
              miss_q <= miss_q + MW'(1);
            end else begin
              // Receiver missed: the opposite player scores and serves next, so the
              // travel direction (towards the loser) is already away from the new server
              if (dir_left_q) begin
                point_right_q <= 1'b1;
                score_right_q <= score_right_q + 4'd1;
                server_left_q <= 1'b0;
              end else begin
                point_left_q  <= 1'b1;
                score_left_q  <= score_left_q + 4'd1;
                server_left_q <= 1'b1;
              end
              lock_left_q  <= 1'b0;
              lock_right_q <= 1'b0;
              miss_q       <= '0;
              pause_q      <= '0;
              state_q      <= POINT;
            end
          end
        end
        POINT: begin
          if (server_score == 4'(WIN_SCORE)) begin
            game_over_q   <= 1'b1;
            winner_left_q <= server_left_q;
            state_q       <= GAME_OVER;
          end else if (pause_q == PW'(POINT_PAUSE - 1)) begin
            state_q <= SERVE;
          end else begin
            pause_q <= pause_q + PW'(1);
          end
        end
        default: begin
          state_q <= GAME_OVER;
        end
      endcase
    end
  end

  assign left_trigger_o  = left_trig_q;
  assign right_trigger_o = right_trig_q;
  assign score_left_o    = score_left_q;
  assign score_right_o   = score_right_q;
  assign point_left_o    = point_left_q;
  assign point_right_o   = point_right_q;
  assign rally_active_o  = (state_q == RALLY);
  assign game_over_o     = game_over_q;
  assign winner_left_o   = winner_left_q;

endmodule

// File: tb/tb_tennis_referee.sv
// tb/tb_tennis_referee.sv - scoreboard bench for tennis_referee
module tb_tennis_referee;

  typedef struct packed {
    logic [3:0] pulses;   // {left_trigger, right_trigger, point_left, point_right}
    logic [3:0] sl;
    logic [3:0] sr;
  } exp_t;

  localparam logic [3:0] P_LT = 4'b1000;
  localparam logic [3:0] P_RT = 4'b0100;
  localparam logic [3:0] P_PL = 4'b0010;
  localparam logic [3:0] P_PR = 4'b0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ball = 16'd0;
  logic        lb = 1'b0;
  logic        rb = 1'b0;
  logic        lt, rt, pl, pr, rally, gover, wleft;
  logic [3:0]  sl, sr;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [3:0] exp_sl = 4'd0;
  logic [3:0] exp_sr = 4'd0;

  tennis_referee dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .ball_i         (ball),
    .left_btn_i     (lb),
    .right_btn_i    (rb),
    .left_trigger_o (lt),
    .right_trigger_o(rt),
    .score_left_o   (sl),
    .score_right_o  (sr),
    .point_left_o   (pl),
    .point_right_o  (pr),
    .rally_active_o (rally),
    .game_over_o    (gover),
    .winner_left_o  (wleft)
  );

  always #5 clk = ~clk;

  // Monitor: every output pulse must match the next expected event
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (lt || rt || pl || pr)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got lt/rt/pl/pr=%b scores=%0d/%0d", {lt, rt, pl, pr}, sl, sr);
      end else begin
        e = q.pop_front();
        if ({lt, rt, pl, pr} != e.pulses || sl != e.sl || sr != e.sr) begin
          errors++;
          $display("FAIL pulse_event got %b %0d/%0d expected %b %0d/%0d",
                   {lt, rt, pl, pr}, sl, sr, e.pulses, e.sl, e.sr);
        end
      end
    end
  end

  task automatic push(input logic [3:0] p);
    exp_t e;
    if (p == P_PL) exp_sl = exp_sl + 4'd1;
    if (p == P_PR) exp_sr = exp_sr + 4'd1;
    e.pulses = p;
    e.sl = exp_sl;
    e.sr = exp_sr;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [15:0] b, input logic l, input logic r);
    ball = b;
    lb = l;
    rb = r;
    @(posedge clk);
    #1;
    lb = 1'b0;
    rb = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    ball = 16'd0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_sl = 4'd0;
    exp_sr = 4'd0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_score_left"}, sl, 0);
    chk({tag, "_score_right"}, sr, 0);
    chk({tag, "_rally"}, rally, 0);
    chk({tag, "_game_over"}, gover, 0);
    chk({tag, "_winner"}, wleft, 0);
  endtask

  // Ball parked on the left end LED long enough for the miss timer to expire
  task automatic left_miss();
    repeat (3) cyc(16'h8000, 1'b0, 1'b0);
    push(P_PR);
    cyc(16'h8000, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    do_reset(3);
    check_idle("reset");

    // Serve: only the right (server) button counts
    cyc(16'h0000, 1'b1, 1'b0);
    chk("serve_wrong_btn_rally", rally, 0);
    push(P_RT);
    cyc(16'h0000, 1'b0, 1'b1);
    chk("serve_rally_active", rally, 1);

    // Rally returns, including window boundaries and a non-receiver press
    push(P_LT); cyc(16'h4000, 1'b1, 1'b0);
    push(P_RT); cyc(16'h0001, 1'b0, 1'b1);
    cyc(16'h0001, 1'b0, 1'b1);
    push(P_LT); cyc(16'h2000, 1'b1, 1'b0);
    push(P_RT); cyc(16'h0004, 1'b0, 1'b1);

    // Early press locks out the left player; the ball then dies on the end LED
    cyc(16'h0800, 1'b1, 1'b0);
    cyc(16'h8000, 1'b1, 1'b0);
    repeat (2) cyc(16'h8000, 1'b0, 1'b0);
    push(P_PR);
    cyc(16'h8000, 1'b0, 1'b0);
    chk("miss_rally_dropped", rally, 0);
    chk("miss_score_right", sr, 1);
    repeat (8) cyc(16'h0000, 1'b1, 1'b1);
    push(P_RT);
    cyc(16'h0000, 1'b0, 1'b1);
    chk("reserve_rally", rally, 1);

    // Return in the expiry cycle wins over the miss
    repeat (3) cyc(16'h8000, 1'b0, 1'b0);
    push(P_LT);
    cyc(16'h8000, 1'b1, 1'b0);
    chk("late_hit_score_right", sr, 1);
    push(P_RT); cyc(16'h0001, 1'b0, 1'b1);

    // Both buttons together: only the receiver acts
    push(P_LT); cyc(16'h4000, 1'b1, 1'b1);

    // Malformed ball positions never score or trigger
    repeat (10) cyc(16'h8001, 1'b0, 1'b0);
    repeat (10) cyc(16'h0000, 1'b0, 1'b0);
    chk("invalid_ball_rally", rally, 1);

    // Press on an invalid ball locks the right player; the end LED then expires
    cyc(16'h8001, 1'b0, 1'b1);
    cyc(16'h0001, 1'b0, 1'b1);
    repeat (2) cyc(16'h0001, 1'b0, 1'b0);
    push(P_PL);
    cyc(16'h0001, 1'b0, 1'b0);
    chk("lock_score_left", sl, 1);
    repeat (8) cyc(16'h0000, 1'b0, 1'b1);
    push(P_LT);
    cyc(16'h0000, 1'b1, 1'b0);

    // Right player runs out the game
    push(P_RT); cyc(16'h0001, 1'b0, 1'b1);
    left_miss();
    for (int i = 0; i < 5; i++) begin
      repeat (8) cyc(16'h0000, 1'b0, 1'b0);
      push(P_RT);
      cyc(16'h0000, 1'b0, 1'b1);
      left_miss();
    end
    repeat (3) cyc(16'h0000, 1'b0, 1'b0);
    chk("end_game_over", gover, 1);
    chk("end_winner_left", wleft, 0);
    chk("end_score_right", sr, 7);
    chk("end_score_left", sl, 1);
    repeat (5) cyc(16'h8000, 1'b1, 1'b1);
    repeat (5) cyc(16'h0001, 1'b1, 1'b1);
    chk("frozen_score_right", sr, 7);
    chk("frozen_game_over", gover, 1);

    // New game, then reset in the middle of the point pause
    do_reset(1);
    check_idle("restart");
    push(P_RT);
    cyc(16'h0000, 1'b0, 1'b1);
    left_miss();
    chk("mid_point_score_right", sr, 1);
    repeat (2) cyc(16'h0000, 1'b0, 1'b0);
    do_reset(1);
    check_idle("mid_point_reset");
    push(P_RT);
    cyc(16'h0000, 1'b0, 1'b1);
    chk("after_reset_serve", rally, 1);

    // Drain the scoreboard within a bounded wait
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
